// File: rtl/ibex_bcp_csr.sv
// CSR bank for the bound-checking path: region entries, control/lock,
// and first-fault capture with a held exception request.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no fault outstanding, next err_ev is captured
// PENDING | fault captured, fault_o held high until fault_ack_i
module ibex_bcp_csr #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned BCPNumRegions   = 4,
    parameter logic [11:0] BcpAddrBase     = 12'h7C0,
    parameter logic [11:0] BcpCtrlAddr     = 12'h7D0,
    parameter logic [11:0] BcpFaultAddr    = 12'h7D1,
    parameter logic [11:0] BcpFaultValAddr = 12'h7D2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  csr_we_i,
    input  logic [11:0]                           csr_addr_i,
    input  logic [XLEN-1:0]                       csr_wdata_i,
    output logic [XLEN-1:0]                       csr_rdata_o,
    output logic                                  csr_hit_o,
    output logic                                  csr_wr_blocked_o,
    output logic [BCPNumRegions-1:0][XLEN-1:0]    csr_bcp_addr_o,
    output logic                                  bcp_en_o,
    input  logic                                  ex_valid_i,
    input  logic                                  bcp_load_addr_err_i,
    input  logic                                  bcp_store_addr_err_i,
    input  logic                                  bcp_arith_addr_err_i,
    input  logic [XLEN-1:0]                       fault_val_i,
    output logic                                  fault_o,
    input  logic                                  fault_ack_i
);

    typedef enum logic {IDLE, PENDING} state_e;

    state_e          state_q, state_d;
    logic            lock_q;
    logic [1:0]      cause_q;
    logic            ovf_q;
    logic [15:0]     count_q;
    logic [XLEN-1:0] faultval_q;

    logic [11:0] entry_idx;
    logic        entry_hit, ctrl_hit, fault_hit, faultval_hit;
    logic        prot_wr, wr_ok, fault_wr;
    logic        err_ev, capture, ovf_set;
    logic [1:0]  new_cause;

    assign entry_idx    = csr_addr_i - BcpAddrBase;
    assign entry_hit    = entry_idx < 12'(BCPNumRegions);
    assign ctrl_hit     = csr_addr_i == BcpCtrlAddr;
    assign fault_hit    = csr_addr_i == BcpFaultAddr;
    assign faultval_hit = csr_addr_i == BcpFaultValAddr;
    assign csr_hit_o    = entry_hit | ctrl_hit | fault_hit | faultval_hit;

    // Entries and bcpctrl are the lockable set; fault registers stay writable.
    assign prot_wr          = csr_we_i & (entry_hit | ctrl_hit);
    assign csr_wr_blocked_o = prot_wr & lock_q;
    assign wr_ok            = prot_wr & ~lock_q;
    assign fault_wr         = csr_we_i & fault_hit;

    assign err_ev = ex_valid_i & bcp_en_o &
                    (bcp_load_addr_err_i | bcp_store_addr_err_i | bcp_arith_addr_err_i);
    assign new_cause = bcp_store_addr_err_i ? 2'd2 :
                       bcp_load_addr_err_i  ? 2'd1 : 2'd3;

    // An ack in the same cycle as a new error re-arms capture immediately.
    assign capture = err_ev & ((state_q == IDLE) | fault_ack_i);
    assign ovf_set = err_ev & (state_q == PENDING) & ~fault_ack_i;
    assign fault_o = (state_q == PENDING);

    // FSM state register; reset drops fault_o without waiting for a clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (err_ev) state_d = PENDING;
            PENDING: if (fault_ack_i && !err_ev) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Region entries and bcpctrl; LOCK can only be set, never cleared by software.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csr_bcp_addr_o <= '0;
            bcp_en_o       <= 1'b0;
            lock_q         <= 1'b0;
        end else begin
            for (int i = 0; i < int'(BCPNumRegions); i++) begin
                if (wr_ok && entry_hit && entry_idx == 12'(i))
                    csr_bcp_addr_o[i] <= csr_wdata_i;
            end
            if (wr_ok && ctrl_hit) begin
                bcp_en_o <= csr_wdata_i[0];
                lock_q   <= csr_wdata_i[1];
            end
        end
    end

    // Fault capture; a same-cycle error overrides the write's clear of CAUSE/COUNT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cause_q    <= 2'd0;
            ovf_q      <= 1'b0;
            count_q    <= 16'd0;
            faultval_q <= '0;
        end else begin
            if (fault_wr) begin
                cause_q <= 2'd0;
                ovf_q   <= 1'b0;
                count_q <= 16'd0;
            end
            if (err_ev) begin
                if (fault_wr)                count_q <= 16'd1;
                else if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
            end
            if (ovf_set && !fault_wr) ovf_q <= 1'b1;
            if (capture) begin
                cause_q    <= new_cause;
                faultval_q <= fault_val_i;
            end
        end
    end

    // Combinational read mux; unmapped addresses read as zero.
    always_comb begin
        csr_rdata_o = '0;
        for (int i = 0; i < int'(BCPNumRegions); i++) begin
            if (entry_hit && entry_idx == 12'(i)) csr_rdata_o = csr_bcp_addr_o[i];
        end
        if (ctrl_hit)     csr_rdata_o = XLEN'({lock_q, bcp_en_o});
        if (fault_hit)    csr_rdata_o = XLEN'({count_q, 13'd0, ovf_q, cause_q});
        if (faultval_hit) csr_rdata_o = faultval_q;
    end

endmodule

// File: tb/tb_ibex_bcp_csr.sv
// Self-checking bench for ibex_bcp_csr: expectations are queued when stimulus
// is applied and popped when the DUT response is sampled.
module tb_ibex_bcp_csr;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             csr_we_i;
    logic [11:0]      csr_addr_i;
    logic [31:0]      csr_wdata_i;
    logic [31:0]      csr_rdata_o;
    logic             csr_hit_o;
    logic             csr_wr_blocked_o;
    logic [3:0][31:0] csr_bcp_addr_o;
    logic             bcp_en_o;
    logic             ex_valid_i;
    logic             bcp_load_addr_err_i;
    logic             bcp_store_addr_err_i;
    logic             bcp_arith_addr_err_i;
    logic [31:0]      fault_val_i;
    logic             fault_o;
    logic             fault_ack_i;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    ibex_bcp_csr dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
        .csr_rdata_o(csr_rdata_o), .csr_hit_o(csr_hit_o),
        .csr_wr_blocked_o(csr_wr_blocked_o), .csr_bcp_addr_o(csr_bcp_addr_o),
        .bcp_en_o(bcp_en_o), .ex_valid_i(ex_valid_i),
        .bcp_load_addr_err_i(bcp_load_addr_err_i),
        .bcp_store_addr_err_i(bcp_store_addr_err_i),
        .bcp_arith_addr_err_i(bcp_arith_addr_err_i),
        .fault_val_i(fault_val_i), .fault_o(fault_o), .fault_ack_i(fault_ack_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        csr_we_i = 0; csr_wdata_i = 0; ex_valid_i = 0;
        bcp_load_addr_err_i = 0; bcp_store_addr_err_i = 0; bcp_arith_addr_err_i = 0;
        fault_val_i = 0; fault_ack_i = 0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_we_i = 1; csr_addr_i = a; csr_wdata_i = d;
        step();
        csr_we_i = 0;
    endtask

    task automatic csr_read(input logic [11:0] a);
        csr_addr_i = a;
        #1;
    endtask

    task automatic err(input logic ld, input logic st, input logic ar, input logic [31:0] v);
        ex_valid_i = 1; bcp_load_addr_err_i = ld; bcp_store_addr_err_i = st;
        bcp_arith_addr_err_i = ar; fault_val_i = v;
    endtask

    task automatic do_reset();
        clear_inputs();
        csr_addr_i = 12'h000;
        rst_i = 1;
        step();
        step();
        rst_i = 0;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        csr_addr_i = 12'h000;
        rst_i = 1;
        #3;
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        exp_v = exp_q.pop_front(); total_cnt++;
        if ({31'd0, fault_o} !== exp_v) $display("FAIL rst_fault_o: got %h want %h", fault_o, exp_v); else pass_cnt++;
        exp_v = exp_q.pop_front(); total_cnt++;
        if ({31'd0, bcp_en_o} !== exp_v) $display("FAIL rst_en: got %h want %h", bcp_en_o, exp_v); else pass_cnt++;
        exp_v = exp_q.pop_front(); total_cnt++;
        if ({31'd0, csr_wr_blocked_o} !== exp_v) $display("FAIL rst_blocked: got %h want %h", csr_wr_blocked_o, exp_v); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(0);
            exp_v = exp_q.pop_front(); total_cnt++;
            if (csr_bcp_addr_o[i] !== exp_v) $display("FAIL rst_entry%0d: got %h want %h", i, csr_bcp_addr_o[i], exp_v); else pass_cnt++;
        end
        for (int a = 12'h7D0; a <= 12'h7D2; a++) begin
            exp_q.push_back(0);
            csr_read(12'(a));
            exp_v = exp_q.pop_front(); total_cnt++;
            if (csr_rdata_o !== exp_v) $display("FAIL rst_read_%h: got %h want %h", a, csr_rdata_o, exp_v); else pass_cnt++;
        end
        step();
        rst_i = 0;
        step();
    endtask

    task automatic test_entry_rw();
        logic [31:0] pat [4];
        pat[0] = 32'h1111_0000; pat[1] = 32'h8012_3400; pat[2] = 32'hA5A5_5A5A; pat[3] = 32'h0000_FFFC;
        csr_we_i = 1; csr_addr_i = 12'h7C1; csr_wdata_i = pat[1];
        #1;
        exp_q.push_back(0);
        exp_v = exp_q.pop_front(); total_cnt++;
        if ({31'd0, csr_wr_blocked_o} !== exp_v) $display("FAIL unlocked_blocked: got %h want %h", csr_wr_blocked_o, exp_v); else pass_cnt++;
        exp_q.push_back(0);
        exp_v = exp_q.pop_front(); total_cnt++;
        if (csr_bcp_addr_o[1] !== exp_v) $display("FAIL entry1_before_edge: got %h want %h", csr_bcp_addr_o[1], exp_v); else pass_cnt++;
        exp_q.push_back(pat[1]);
        step();
        csr_we_i = 0;
        exp_v = exp_q.pop_front(); total_cnt++;
        if (csr_bcp_addr_o[1] !== exp_v) $display("FAIL entry1_out: got %h want %h", csr_bcp_addr_o[1], exp_v); else pass_cnt++;
        for (int i = 0; i < 4; i++) if (i != 1) csr_write(12'h7C0 + 12'(i), pat[i]);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(pat[i]);
            csr_read(12'h7C0 + 12'(i));
            exp_v = exp_q.pop_front(); total_cnt++;
            if (csr_rdata_o !== exp_v || csr_hit_o !== 1'b1) $display("FAIL entry%0d_read: got %h hit %b want %h hit 1", i, csr_rdata_o, csr_hit_o, exp_v); else pass_cnt++;
        end
        exp_q.push_back(0);
        csr_read(12'h7C5);
        exp_v = exp_q.pop_front(); total_cnt++;
        if (csr_rdata_o !== exp_v || csr_hit_o !== 1'b0) $display("FAIL unmapped_read: got %h hit %b want %h hit 0", csr_rdata_o, csr_hit_o, exp_v); else pass_cnt++;
        csr_write(12'h7C0, 32'h0);
    endtask

    task automatic test_lock();
        csr_write(12'h7D0, 32'hFFFF_FFF3);
        exp_q.push_back(32'h3);
        csr_read(12'h7D0);
        exp_v = exp_q.pop_front(); total_cnt++;
        if (csr_rdata_o !== exp_v) $display("FAIL ctrl_read: got %h want %h", csr_rdata_o, exp_v); else pass_cnt++;
        csr_we_i = 1; csr_addr_i = 12'h7C0; csr_wdata_i = 32'hFFFF_FFFF;
        #1;
        exp_q.push_back(1);
        exp_v = exp_q.pop_front(); total_cnt++;
        if ({31'd0, csr_wr_blocked_o} !== exp_v) $display("FAIL entry_blocked: got %h want %h", csr_wr_blocked_o, exp_v); else pass_cnt++;
        exp_q.push_back(0);
        step();
        csr_we_i = 0;
        exp_v = exp_q.pop_front(); total_cnt++;
        if (csr_bcp_addr_o[0] !== exp_v) $display("FAIL locked_entry0: got %h want %h", csr_bcp_addr_o[0], exp_v); else pass_cnt++;
        csr_we_i = 1; csr_addr_i = 12'h7D0; csr_wdata_i = 32'h0;
        #1;
        exp_q.push_back(1);
        exp_v = exp_q.pop_front(); total_cnt++;
        if ({31'd0, csr_wr_blocked_o} !== exp_v) $display("FAIL ctrl_blocked: got %h want %h", csr_wr_blocked_o, exp_v); else pass_cnt++;
        exp_q.push_back(32'h3);
        step();
        csr_we_i = 0;
        csr_read(12'h7D0);
        exp_v = exp_q.pop_front(); total_cnt++;
        if (csr_rdata_o !== exp_v || bcp_en_o !== 1'b1) $display("FAIL ctrl_after_lock: got %h en %b want %h en 1", csr_rdata_o, bcp_en_o, exp_v); else pass_cnt++;
    endtask

    task automatic test_capture();
        err(1, 1, 0, 32'hC000_0010);
        #1;
        exp_q.push_back(0);
        exp_v = exp_q.pop_front(); total_cnt++;
        if ({31'd0, fault_o} !== exp_v) $display("FAIL fault_before_edge: got %h want %h", fault_o, exp_v); else pass_cnt++;
        exp_q.push_back(1); exp_q.push_back(32'h0001_0002); exp_q.push_back(32'hC000_0010);
        step();
        clear_inputs();
        exp_v = exp_q.pop_front(); total_cnt++;
        if ({31'd0, fault_o} !== exp_v) $display("FAIL capture_fault_o: got %h want %h", fault_o, exp_v); else pass_cnt++;
        csr_read(12'h7D1);
        exp_v = exp_q.pop_front(); total_cnt++;
        if (csr_rdata_o !== exp_v) $display("FAIL capture_bcpfault: got %h want %h", csr_rdata_o, exp_v); else pass_cnt++;
        csr_read(12'h7D2);
        exp_v = exp_q.pop_front(); total_cnt++;
        if (csr_rdata_o !== exp_v) $display("FAIL capture_faultval: got %h want %h", csr_rdata_o, exp_v); else pass_cnt++;
    endtask

    task automatic test_overflow_ack();
        err(0, 0, 1, 32'hDEAD_0000);
        exp_q.push_back(32'h0002_0006); exp_q.push_back(32'hC000_0010); exp_q.push_back(1);
        step();
        clear_inputs();
        csr_read(12'h7D1);
        exp_v = exp_q.pop_front(); total_cnt++;
        if (csr_rdata_o !== exp_v) $display("FAIL ovf_bcpfault: got %h want %h", csr_rdata_o, exp_v); else pass_cnt++;
        csr_read(12'h7D2);
        exp_v = exp_q.pop_front(); total_cnt++;
        if (csr_rdata_o !== exp_v) $display("FAIL ovf_faultval_hold: got %h want %h", csr_rdata_o, exp_v); else pass_cnt++;
        exp_v = exp_q.pop_front(); total_cnt++;
        if ({31'd0, fault_o} !== exp_v) $display("FAIL ovf_fault_o: got %h want %h", fault_o, exp_v); else pass_cnt++;
        fault_ack_i = 1;
        exp_q.push_back(0);
        step();
        fault_ack_i = 0;
        exp_v = exp_q.pop_front(); total_cnt++;
        if ({31'd0, fault_o} !== exp_v) $display("FAIL ack_fault_o: got %h want %h", fault_o, exp_v); else pass_cnt++;
        fault_ack_i = 1;
        exp_q.push_back(0); exp_q.push_back(32'h0002_0006);
        step();
        fault_ack_i = 0;
        exp_v = exp_q.pop_front(); total_cnt++;
        if ({31'd0, fault_o} !== exp_v) $display("FAIL idle_ack_fault_o: got %h want %h", fault_o, exp_v); else pass_cnt++;
        csr_read(12'h7D1);
        exp_v = exp_q.pop_front(); total_cnt++;
        if (csr_rdata_o !== exp_v) $display("FAIL idle_ack_bcpfault: got %h want %h", csr_rdata_o, exp_v); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        err(1, 0, 0, 32'h1111_0000);
        step();
        clear_inputs();
        err(0, 0, 1, 32'h2222_0000);
        fault_ack_i = 1;
        exp_q.push_back(1); exp_q.push_back(32'h0004_0007); exp_q.push_back(32'h2222_0000);
        step();
        clear_inputs();
        exp_v = exp_q.pop_front(); total_cnt++;
        if ({31'd0, fault_o} !== exp_v) $display("FAIL b2b_fault_o: got %h want %h", fault_o, exp_v); else pass_cnt++;
        csr_read(12'h7D1);
        exp_v = exp_q.pop_front(); total_cnt++;
        if (csr_rdata_o !== exp_v) $display("FAIL b2b_bcpfault: got %h want %h", csr_rdata_o, exp_v); else pass_cnt++;
        csr_read(12'h7D2);
        exp_v = exp_q.pop_front(); total_cnt++;
        if (csr_rdata_o !== exp_v) $display("FAIL b2b_faultval: got %h want %h", csr_rdata_o, exp_v); else pass_cnt++;
        fault_ack_i = 1;
        step();
        fault_ack_i = 0;
        csr_we_i = 1; csr_addr_i = 12'h7D1; csr_wdata_i = 32'hFFFF_FFFF;
        err(0, 1, 1, 32'h3333_0000);
        #1;
        exp_q.push_back(0);
        exp_v = exp_q.pop_front(); total_cnt++;
        if ({31'd0, csr_wr_blocked_o} !== exp_v) $display("FAIL fault_wr_blocked: got %h want %h", csr_wr_blocked_o, exp_v); else pass_cnt++;
        exp_q.push_back(32'h0001_0002); exp_q.push_back(1);
        step();
        clear_inputs();
        csr_read(12'h7D1);
        exp_v = exp_q.pop_front(); total_cnt++;
        if (csr_rdata_o !== exp_v) $display("FAIL wr_vs_err_bcpfault: got %h want %h", csr_rdata_o, exp_v); else pass_cnt++;
        exp_v = exp_q.pop_front(); total_cnt++;
        if ({31'd0, fault_o} !== exp_v) $display("FAIL wr_vs_err_fault_o: got %h want %h", fault_o, exp_v); else pass_cnt++;
        csr_write(12'h7D2, 32'h0);
        exp_q.push_back(32'h3333_0000);
        csr_read(12'h7D2);
        exp_v = exp_q.pop_front(); total_cnt++;
        if (csr_rdata_o !== exp_v) $display("FAIL faultval_readonly: got %h want %h", csr_rdata_o, exp_v); else pass_cnt++;
    endtask

    task automatic test_disable_and_async_reset();
        do_reset();
        csr_write(12'h7D0, 32'h1);
        err(1, 0, 0, 32'h0000_0040);
        step();
        clear_inputs();
        fault_ack_i = 1;
        step();
        fault_ack_i = 0;
        csr_write(12'h7D0, 32'h0);
        err(1, 1, 1, 32'h0000_0080);
        exp_q.push_back(0); exp_q.push_back(32'h0001_0001);
        step();
        step();
        clear_inputs();
        exp_v = exp_q.pop_front(); total_cnt++;
        if ({31'd0, fault_o} !== exp_v) $display("FAIL disabled_fault_o: got %h want %h", fault_o, exp_v); else pass_cnt++;
        csr_read(12'h7D1);
        exp_v = exp_q.pop_front(); total_cnt++;
        if (csr_rdata_o !== exp_v) $display("FAIL disabled_count: got %h want %h", csr_rdata_o, exp_v); else pass_cnt++;
        csr_write(12'h7D0, 32'h1);
        err(0, 1, 0, 32'h0000_00C0);
        exp_q.push_back(1);
        step();
        clear_inputs();
        exp_v = exp_q.pop_front(); total_cnt++;
        if ({31'd0, fault_o} !== exp_v) $display("FAIL pre_reset_fault_o: got %h want %h", fault_o, exp_v); else pass_cnt++;
        #1;
        rst_i = 1;
        exp_q.push_back(0); exp_q.push_back(0);
        #1;
        exp_v = exp_q.pop_front(); total_cnt++;
        if ({31'd0, fault_o} !== exp_v) $display("FAIL async_reset_fault_o: got %h want %h", fault_o, exp_v); else pass_cnt++;
        csr_read(12'h7D1);
        exp_v = exp_q.pop_front(); total_cnt++;
        if (csr_rdata_o !== exp_v) $display("FAIL async_reset_bcpfault: got %h want %h", csr_rdata_o, exp_v); else pass_cnt++;
        step();
        rst_i = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_entry_rw();
        test_lock();
        test_capture();
        test_overflow_ack();
        test_back_to_back();
        test_disable_and_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ibex_bcp_csr.md
Name: ibex_bcp_csr

Overview:
- CSR bank for the bound-checking path (BCP): holds the region bound entries, the control/lock register and fault-capture registers.
- Drives the region-entry array and enable into the combinational bound checker.
- Consumes the checker's load/store/arith error flags: records the first fault and raises a held exception request until the controller acknowledges it.

Parameters:
XLEN, 32, data width; only 32 supported
BCPNumRegions, 4, number of region entries; even, >=4
BcpAddrBase, 12'h7C0, CSR address of entry 0; entry i at BcpAddrBase+i
BcpCtrlAddr, 12'h7D0, CSR address of bcpctrl
BcpFaultAddr, 12'h7D1, CSR address of bcpfault
BcpFaultValAddr, 12'h7D2, CSR address of bcpfaultval

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
csr_we_i  in  1  CSR write strobe, single cycle
csr_addr_i  in  12  CSR address (read and write)
csr_wdata_i  in  32  CSR write data
csr_rdata_o  out  32  CSR read data, combinational from csr_addr_i
csr_hit_o  out  1  csr_addr_i decodes to a register in this block
csr_wr_blocked_o  out  1  write ignored due to lock (same cycle as csr_we_i)
csr_bcp_addr_o  out  32 x BCPNumRegions  region entries to bound checker
bcp_en_o  out  1  bcpctrl.EN
ex_valid_i  in  1  instruction in EX retires this cycle
bcp_load_addr_err_i  in  1  load bound error from checker
bcp_store_addr_err_i  in  1  store bound error from checker
bcp_arith_addr_err_i  in  1  arith/setag bound error from checker
fault_val_i  in  32  faulting address (adder result) from EX
fault_o  out  1  BCP exception request, level, held until ack
fault_ack_i  in  1  controller accepted exception

Behaviour:
- Reset: all entries 0, bcpctrl 0 (EN=0, LOCK=0), bcpfault 0, bcpfaultval 0, state IDLE, fault_o=0, csr_wr_blocked_o=0.
- Writes take effect at the next rising edge; csr_bcp_addr_o/bcp_en_o are register outputs (1-cycle write-to-use latency). Reads are combinational; unmapped address -> rdata 0, csr_hit_o=0.
- bcpctrl: bit0 EN, bit1 LOCK, other bits read 0. LOCK is sticky: once 1 it clears only by reset.
- When LOCK=1, writes to entries and bcpctrl are dropped and csr_wr_blocked_o=1 that cycle. bcpfault/bcpfaultval remain writable.
- A write setting LOCK takes effect with the EN value from the same write.
- bcpfault layout: [1:0] CAUSE (0 none, 1 load, 2 store, 3 arith), [2] OVF, [15:3] 0, [31:16] COUNT. Any write clears CAUSE, OVF and COUNT, regardless of data.
- bcpfaultval: read-only; writes ignored.
- err_ev = ex_valid_i & bcp_en_o & (load | store | arith err).
- Cause priority when several flags are set: store > load > arith.
- COUNT: incremented on every err_ev, saturates at 16'hFFFF.
- FSM IDLE:
  - err_ev -> capture CAUSE and fault_val_i, go to PENDING; fault_o=1 from the next cycle.
- FSM PENDING:
  - fault_o=1; CAUSE and bcpfaultval hold.
  - err_ev without ack -> OVF=1, no capture.
  - fault_ack_i without err_ev -> IDLE; fault_o=0 next cycle.
  - fault_ack_i with err_ev -> capture the new fault, stay PENDING, fault_o stays 1.
- fault_ack_i in IDLE: ignored.
- EN cleared while PENDING: no effect on the pending fault; new errors are not recorded.
- Same-cycle bcpfault write and err_ev: the capture wins for CAUSE; OVF cleared; COUNT becomes 1.
- Reset mid-PENDING: fault_o drops immediately (asynchronous); all state returns to reset values.

Test Plan:
1. Reset, write 0x8012_3400 to 12'h7C1 -> csr_bcp_addr_o[1]=0x8012_3400 the next cycle; read 12'h7C1 returns the same; read 12'h7C5 -> rdata 0, csr_hit_o=0.
2. Write bcpctrl=3 (EN+LOCK), then write 12'h7C0=0xFFFF_FFFF -> csr_wr_blocked_o=1, entry 0 stays 0. Write bcpctrl=0 -> blocked, bcpctrl reads 3.
3. EN=1: ex_valid_i=1 with load and store errs both set, fault_val_i=0xC000_0010 -> next cycle fault_o=1, bcpfault=0x0001_0002, bcpfaultval=0xC000_0010.
4. While PENDING, an arith err without ack -> OVF=1, COUNT=2, CAUSE stays 2. Then fault_ack_i alone -> IDLE, fault_o=0 next cycle.
5. PENDING with fault_ack_i and an arith err in the same cycle -> fault_o stays 1, CAUSE=3, bcpfaultval updated. Write bcpfault in the same cycle as a new err_ev -> COUNT=1, OVF=0.
6. With EN=0, assert errors with ex_valid_i=1 -> no fault_o, COUNT unchanged. Assert rst_i while PENDING -> fault_o=0 immediately, without waiting for a clock edge.
